// File: rtl/pwm_capture_pkg.sv
// Shared types and helpers for the PWM capture block.
package pwm_capture_pkg;

    // Measurement FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Ceiling log2; used to size counters from their maximum value.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Input synchroniser for the PWM pin plus single-cycle rise/fall pulses.
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchroniser shift chain followed by the edge-detect history flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time in clk_en_i ticks and flags a stuck line.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int COUNTER_BITWIDTH = 9,
    parameter int TIMEOUT_TICKS    = 511,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clk_en_i,
    input  logic                        PWM_pin_i,
    output logic [COUNTER_BITWIDTH-1:0] period_o,
    output logic [COUNTER_BITWIDTH-1:0] highTime_o,
    output logic                        dataValid_STRB_o,
    output logic                        stuck_o,
    output logic                        stuckLevel_o
);

    localparam int CB     = COUNTER_BITWIDTH;
    localparam int IDLE_W = clog2(TIMEOUT_TICKS + 1);

    logic level, rise, fall, edge_any;
    logic timeout;
    logic start, latch_high, report;

    state_t state_q, state_d;

    logic [CB-1:0]     period_cnt_q, high_cnt_q, high_shadow_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic              frozen_q;
    logic [CB-1:0]     tick_cb;
    logic [IDLE_W-1:0] tick_idle;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk_i),
        .rst  (rst_i),
        .pin  (PWM_pin_i),
        .level(level),
        .rise (rise),
        .fall (fall)
    );

    assign edge_any  = rise | fall;
    assign tick_cb   = {{(CB-1){1'b0}}, clk_en_i};
    assign tick_idle = {{(IDLE_W-1){1'b0}}, clk_en_i};
    // An edge in the same cycle always beats the timeout; once fired the
    // timer stays frozen until the next edge so only one stuck strobe is sent.
    assign timeout   = !edge_any && !frozen_q &&
                       (idle_cnt_q == IDLE_W'(TIMEOUT_TICKS));

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and control decode.
    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        latch_high = 1'b0;
        report     = 1'b0;
        if (timeout) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (rise) begin
                    start   = 1'b1;
                    state_d = HIGH;
                end
                HIGH: if (fall) begin
                    latch_high = 1'b1;
                    state_d    = LOW;
                end
                LOW: if (rise) begin
                    report  = 1'b1;
                    start   = 1'b1;
                    state_d = HIGH;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Period/high counters include the start-edge tick and exclude the end-edge tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_cnt_q  <= '0;
            high_cnt_q    <= '0;
            high_shadow_q <= '0;
        end else begin
            if (start) begin
                period_cnt_q <= tick_cb;
                high_cnt_q   <= tick_cb;
            end else begin
                period_cnt_q <= period_cnt_q + tick_cb;
                if (state_q == HIGH) high_cnt_q <= high_cnt_q + tick_cb;
            end
            if (latch_high) high_shadow_q <= high_cnt_q;
        end
    end

    // Edge-free tick timer used for stuck-line detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idle_cnt_q <= '0;
            frozen_q   <= 1'b0;
        end else if (edge_any) begin
            idle_cnt_q <= tick_idle;
            frozen_q   <= 1'b0;
        end else if (timeout) begin
            frozen_q   <= 1'b1;
        end else if (!frozen_q) begin
            idle_cnt_q <= idle_cnt_q + tick_idle;
        end
    end

    // Output registers; they hold between strobes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_o         <= '0;
            highTime_o       <= '0;
            stuck_o          <= 1'b0;
            stuckLevel_o     <= 1'b0;
            dataValid_STRB_o <= 1'b0;
        end else begin
            dataValid_STRB_o <= report | timeout;
            if (report) begin
                period_o   <= period_cnt_q;
                highTime_o <= high_shadow_q;
                stuck_o    <= 1'b0;
            end else if (timeout) begin
                period_o     <= '0;
                highTime_o   <= '0;
                stuck_o      <= 1'b1;
                stuckLevel_o <= level;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: expected reports queued as stimulus is driven.
module tb_pwm_capture;

    localparam int CB = 9;

    typedef struct packed {
        logic [CB-1:0] per;
        logic [CB-1:0] hi;
        logic          stk;
        logic          lvl;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_en = 1'b1;
    logic          pin = 1'b0;
    logic [CB-1:0] period, high_time;
    logic          strobe, stuck, stuck_level;

    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   en_div = 1;
    exp_t exp_q[$];

    pwm_capture #(
        .COUNTER_BITWIDTH(CB),
        .TIMEOUT_TICKS   (511),
        .SYNC_STAGES     (2)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .clk_en_i        (clk_en),
        .PWM_pin_i       (pin),
        .period_o        (period),
        .highTime_o      (high_time),
        .dataValid_STRB_o(strobe),
        .stuck_o         (stuck),
        .stuckLevel_o    (stuck_level)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (strobe === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: got per=%0d hi=%0d stuck=%0b lvl=%0b, none expected",
                         period, high_time, stuck, stuck_level);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({period, high_time, stuck, stuck_level} !== {e.per, e.hi, e.stk, e.lvl}) begin
                    fails++;
                    $display("FAIL strobe_data: got per=%0d hi=%0d stuck=%0b lvl=%0b, want per=%0d hi=%0d stuck=%0b lvl=%0b",
                             period, high_time, stuck, stuck_level, e.per, e.hi, e.stk, e.lvl);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        clk_en = ((cyc % en_div) == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic push(input int p, input int h, input bit s, input bit l, input int n);
        exp_t e;
        e.per = CB'(p);
        e.hi  = CB'(h);
        e.stk = s;
        e.lvl = l;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // n full periods from IDLE, then a closing rise; pin stays high afterwards.
    task automatic pwm(input int p, input int h, input int n, input bit chk_lat);
        for (int i = 0; i < n; i++) begin
            pin = 1'b1;
            for (int c = 1; c <= p; c++) begin
                step();
                if (chk_lat && i == 1 && c == 2) begin
                    checks++;
                    if (strobe !== 1'b0) begin
                        fails++;
                        $display("FAIL latency_early: got strobe=%b, want 0", strobe);
                    end
                end
                if (chk_lat && i == 1 && c == 3) begin
                    checks++;
                    if (strobe !== 1'b1) begin
                        fails++;
                        $display("FAIL latency_edge: got strobe=%b, want 1", strobe);
                    end
                end
                if (c == h) pin = 1'b0;
            end
        end
        pin = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < 1000 && exp_q.size() != 0; k++) step();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Counts steps until a strobe is seen (0 if none within the bound).
    task automatic wait_strobe(input int limit, output int at);
        at = 0;
        for (int k = 1; k <= limit && at == 0; k++) begin
            step();
            if (strobe === 1'b1) at = k;
        end
    endtask

    task automatic test_reset();
        pin = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({period, high_time, strobe, stuck, stuck_level} !== '0) begin
            fails++;
            $display("FAIL reset_state: got per=%0d hi=%0d strb=%b stuck=%b lvl=%b, want all 0",
                     period, high_time, strobe, stuck, stuck_level);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        pin = 1'b0;
        do_reset();
        push(100, 30, 1'b0, 1'b0, 3);
        pwm(100, 30, 3, 1'b1);
        drain();
    endtask

    task automatic test_clk_en();
        pin = 1'b0;
        do_reset();
        en_div = 4;
        push(100, 25, 1'b0, 1'b0, 2);
        pwm(400, 100, 2, 1'b0);
        drain();
        en_div = 1;
    endtask

    task automatic test_stuck_high();
        int at;
        pin = 1'b1;
        do_reset();
        push(0, 0, 1'b1, 1'b1, 1);
        wait_strobe(700, at);
        checks++;
        if (at != 514) begin
            fails++;
            $display("FAIL stuck_high_time: got %0d cycles, want 514", at);
        end
        drain();
    endtask

    task automatic test_stuck_low();
        int at;
        pin = 1'b0;
        do_reset();
        push(0, 0, 1'b1, 1'b0, 1);
        wait_strobe(700, at);
        checks++;
        if (at != 512) begin
            fails++;
            $display("FAIL stuck_low_time: got %0d cycles, want 512", at);
        end
        drain();
        repeat (600) step();
        checks++;
        if ({stuck, period, high_time} !== {1'b1, {CB{1'b0}}, {CB{1'b0}}}) begin
            fails++;
            $display("FAIL stuck_hold: got stuck=%b per=%0d hi=%0d, want 1/0/0", stuck, period, high_time);
        end
    endtask

    task automatic test_recover();
        push(50, 10, 1'b0, 1'b0, 2);
        pwm(50, 10, 2, 1'b0);
        drain();
        checks++;
        if (stuck !== 1'b0) begin
            fails++;
            $display("FAIL recover_stuck: got %b, want 0", stuck);
        end
    endtask

    task automatic test_reset_mid_high();
        pin = 1'b0;
        do_reset();
        push(100, 30, 1'b0, 1'b0, 1);
        pwm(100, 30, 1, 1'b0);
        drain();
        repeat (10) step();
        rst = 1'b1;
        step();
        checks++;
        if ({period, high_time, strobe, stuck} !== '0) begin
            fails++;
            $display("FAIL mid_reset: got per=%0d hi=%0d strb=%b stuck=%b, want all 0",
                     period, high_time, strobe, stuck);
        end
        pin = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        push(100, 30, 1'b0, 1'b0, 1);
        pwm(100, 30, 1, 1'b0);
        drain();
    endtask

    task automatic test_edge_at_timeout();
        pin = 1'b0;
        do_reset();
        repeat (509) step();
        push(100, 30, 1'b0, 1'b0, 1);
        pwm(100, 30, 1, 1'b0);
        drain();
        checks++;
        if (stuck !== 1'b0) begin
            fails++;
            $display("FAIL edge_vs_timeout: got stuck=%b, want 0", stuck);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_clk_en();
        test_stuck_high();
        test_stuck_low();
        test_recover();
        test_reset_mid_high();
        test_edge_at_timeout();
        repeat (5) step();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
